regfile_write_arbiter: RTL and testbench

Shares the single synchronous write port of the 32x32 MIPS register file between two writeback requesters: A (ALU result) and B (load/memory result). Each cycle it grants at most one requester via a valid/ready handshake and drives a registered write (RegWrite/WriteRegister/WriteData) to the register file. Writes that target register 0 complete the handshake but are discarded. A saturating conflict counter is provided for performance tuning.

---
 rtl/regfile_write_arbiter.sv | 78 +++++++
 tb/tb_regfile_write_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter for the 32x32 register file write port, with a saturating conflict counter.
// Define REGARB_FIXED_PRIORITY_EN for fixed priority (A always wins); round-robin by default.
module regfile_write_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValidA,
  input  logic [4:0]  ReqRegA,
  input  logic [31:0] ReqDataA,
  output logic        ReqReadyA,
  input  logic        ReqValidB,
  input  logic [4:0]  ReqRegB,
  input  logic [31:0] ReqDataB,
  output logic        ReqReadyB,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic [15:0] ConflictCount
);

  logic        grant_a;
  logic        grant_b;
  logic        xfer;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;

`ifdef REGARB_FIXED_PRIORITY_EN
  assign grant_a = ReqValidA;
  assign grant_b = ReqValidB & ~ReqValidA;
`else
  // pri_reg: 0 favours A, 1 favours B; flips to the other side after each transfer.
  logic pri_reg;

  assign grant_a = ReqValidA & (~ReqValidB | ~pri_reg);
  assign grant_b = ReqValidB & (~ReqValidA | pri_reg);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pri_reg <= 1'b0;
    end else if (grant_a) begin
      pri_reg <= 1'b1;
    end else if (grant_b) begin
      pri_reg <= 1'b0;
    end
  end
`endif

  // Readies are masked while reset is held so no handshake completes during reset.
  assign ReqReadyA = grant_a & ~Reset;
  assign ReqReadyB = grant_b & ~Reset;

  assign xfer     = grant_a | grant_b;
  assign sel_reg  = grant_a ? ReqRegA : ReqRegB;
  assign sel_data = grant_a ? ReqDataA : ReqDataB;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      RegWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= 32'd0;
    end else begin
      RegWrite <= xfer && (sel_reg != 5'd0);
      // Writes to register 0 still handshake but leave the address/data stage untouched.
      if (xfer && (sel_reg != 5'd0)) begin
        WriteRegister <= sel_reg;
        WriteData     <= sel_data;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ConflictCount <= 16'd0;
    end else if (ReqValidA && ReqValidB && (ConflictCount != 16'hFFFF)) begin
      ConflictCount <= ConflictCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: vector table plus hand-written reset, collision and saturation sequences.
module tb_regfile_write_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValidA, ReqValidB;
  logic [4:0]  ReqRegA, ReqRegB;
  logic [31:0] ReqDataA, ReqDataB;
  logic        ReqReadyA, ReqReadyB;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [15:0] ConflictCount;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        va;
    logic [4:0]  ra;
    logic [31:0] da;
    logic        vb;
    logic [4:0]  rb;
    logic [31:0] db;
    logic        ea;
    logic        eb;
    logic [15:0] conf;
  } vec_t;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  logic [31:0] rf [32];

  always #5 Clk = ~Clk;

  regfile_write_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValidA(ReqValidA), .ReqRegA(ReqRegA), .ReqDataA(ReqDataA), .ReqReadyA(ReqReadyA),
    .ReqValidB(ReqValidB), .ReqRegB(ReqRegB), .ReqDataB(ReqDataB), .ReqReadyB(ReqReadyB),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ConflictCount(ConflictCount)
  );

  // Behavioural register file fed by the arbiter's write port; no reset, like the real array.
  always @(posedge Clk) begin
    if (RegWrite && (WriteRegister != 5'd0)) rf[WriteRegister] <= WriteData;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag);
    wr_t w;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check({tag, " RegWrite"}, {31'd0, RegWrite}, 32'd1);
      check({tag, " WriteRegister"}, {27'd0, WriteRegister}, {27'd0, w.r});
      check({tag, " WriteData"}, WriteData, w.d);
    end else begin
      check({tag, " RegWrite idle"}, {31'd0, RegWrite}, 32'd0);
    end
  endtask

  // One transaction: drive at negedge, check readies, push expected write, clock, check output stage.
  task automatic step(input string tag, input vec_t v, input logic chk_conf);
    wr_t w;
    @(negedge Clk);
    ReqValidA = v.va; ReqRegA = v.ra; ReqDataA = v.da;
    ReqValidB = v.vb; ReqRegB = v.rb; ReqDataB = v.db;
    #1;
    check({tag, " ReqReadyA"}, {31'd0, ReqReadyA}, {31'd0, v.ea});
    check({tag, " ReqReadyB"}, {31'd0, ReqReadyB}, {31'd0, v.eb});
    if (v.ea && v.ra != 5'd0) begin w.r = v.ra; w.d = v.da; exp_q.push_back(w); end
    if (v.eb && v.rb != 5'd0) begin w.r = v.rb; w.d = v.db; exp_q.push_back(w); end
    @(posedge Clk);
    #1;
    check_out(tag);
    if (chk_conf) check({tag, " ConflictCount"}, {16'd0, ConflictCount}, {16'd0, v.conf});
    $display("txn %s vA=%0b vB=%0b rdyA=%0b rdyB=%0b RegWrite=%0b WR=%0d WD=%h cc=%0d",
             tag, v.va, v.vb, v.ea, v.eb, RegWrite, WriteRegister, WriteData, ConflictCount);
  endtask

  task automatic idle_inputs();
    ReqValidA = 0; ReqRegA = 0; ReqDataA = 0;
    ReqValidB = 0; ReqRegB = 0; ReqDataB = 0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    idle_inputs();
    Reset = 1'b1;
    #1;
    check("reset RegWrite", {31'd0, RegWrite}, 32'd0);
    check("reset WriteRegister", {27'd0, WriteRegister}, 32'd0);
    check("reset WriteData", WriteData, 32'd0);
    check("reset ConflictCount", {16'd0, ConflictCount}, 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    exp_q.delete();
  endtask

  function automatic vec_t mk(input logic va, input logic [4:0] ra, input logic [31:0] da,
                              input logic vb, input logic [4:0] rb, input logic [31:0] db,
                              input logic ea, input logic eb, input logic [15:0] conf);
    vec_t v;
    v.va = va; v.ra = ra; v.da = da; v.vb = vb; v.rb = rb; v.db = db;
    v.ea = ea; v.eb = eb; v.conf = conf;
    return v;
  endfunction

  initial begin
    vec_t tbl [11];
    vec_t nothing;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    Reset = 1'b0;
    idle_inputs();
    nothing = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef REGARB_FIXED_PRIORITY_EN
    do_reset();
    for (int i = 0; i < 3; i++)
      step($sformatf("fixed%0d", i), mk(1, 1, 32'hA0 + i, 1, 2, 32'hB0 + i, 1, 0, 16'(i + 1)), 1'b1);
`else
    // Round-robin sequence starting from a fresh reset (Pri favours A).
    tbl[0]  = mk(1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 16'd1);
    tbl[1]  = mk(1, 1, 32'h12, 1, 2, 32'h22, 0, 1, 16'd2);
    tbl[2]  = mk(1, 1, 32'h12, 1, 2, 32'h23, 1, 0, 16'd3);
    tbl[3]  = mk(1, 1, 32'h13, 1, 2, 32'h23, 0, 1, 16'd4);
    tbl[4]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 16'd4);
    tbl[5]  = mk(1, 6, 32'h66, 0, 0, 0, 1, 0, 16'd4);
    tbl[6]  = mk(0, 0, 0, 1, 3, 32'h33, 0, 1, 16'd4);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 16'd4);
    tbl[8]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 16'd4);
    tbl[9]  = mk(1, 7, 32'h1, 1, 7, 32'h2, 0, 1, 16'd5);
    tbl[10] = mk(1, 7, 32'h1, 0, 0, 0, 1, 0, 16'd5);
    do_reset();
    for (int i = 0; i < 11; i++) step($sformatf("vec%0d", i), tbl[i], 1'b1);
    step("drain", nothing, 1'b0);
    check("rf[5]", rf[5], 32'hDEADBEEF);
    check("rf[6]", rf[6], 32'h66);
    check("rf[3]", rf[3], 32'h33);
    check("rf[7] after B then A", rf[7], 32'h1);

    // Same-register collision from fresh reset: A first, then B; B's data remains.
    do_reset();
    step("coll0", mk(1, 7, 32'h1, 1, 7, 32'h2, 1, 0, 16'd1), 1'b1);
    step("coll1", mk(0, 0, 0, 1, 7, 32'h2, 0, 1, 16'd1), 1'b1);
    step("coll2", nothing, 1'b0);
    check("rf[7] collision", rf[7], 32'h2);
`endif

    // Asynchronous reset one cycle after a B grant drops the pending write.
    do_reset();
    step("preB", mk(0, 0, 0, 1, 9, 32'h99, 0, 1, 16'd0), 1'b1);
    #2;
    ReqValidB = 1'b0;
    ReqValidA = 1'b1; ReqRegA = 5'd4; ReqDataA = 32'h44;
    Reset = 1'b1;
    #1;
    check("async RegWrite", {31'd0, RegWrite}, 32'd0);
    check("async WriteData", WriteData, 32'd0);
    check("async ReqReadyA", {31'd0, ReqReadyA}, 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    idle_inputs();
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rf[9] untouched", rf[9], 32'd0);
    check("rf[4] untouched", rf[4], 32'd0);

    // Saturation: both valid long enough to pass 16'hFFFF.
    do_reset();
    @(negedge Clk);
    ReqValidA = 1; ReqRegA = 5'd10; ReqDataA = 32'hA;
    ReqValidB = 1; ReqRegB = 5'd11; ReqDataB = 32'hB;
    repeat (65534) @(posedge Clk);
    #1;
    check("ConflictCount 65534", {16'd0, ConflictCount}, 32'd65534);
    repeat (70000 - 65534) @(posedge Clk);
    #1;
    check("ConflictCount saturated", {16'd0, ConflictCount}, 32'h0000FFFF);
    $display("txn saturate cycles=70000 cc=%h", ConflictCount);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
